cluster_finder: RTL and testbench

Sequential cluster finder for one 128-strip row of the data compression logic. It captures a 128-bit hit map and emits one cluster word per cycle, scanning from the highest strip address downward. Each word holds a 7-bit seed address and a 3-bit pattern for the next three lower strips. The block consumes the 4-bit strip window it reports, then continues until the map is empty or the cluster cap is reached. It sits between hit-map capture (upstream) and cluster packing/readout (downstream).

---
 rtl/cluster_finder_pkg.sv | 20 ++
 rtl/cluster_finder_if.sv | 28 ++
 rtl/cluster_prio_enc.sv | 33 +++
 rtl/cluster_finder.sv | 140 ++++++++++++++
 tb/tb_cluster_finder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cluster_finder_pkg.sv
// Shared definitions for the cluster finder: geometry, FSM states and
// the cluster word layout.
package cluster_finder_pkg;

   localparam int STRIPS = 128;
   localparam int ADDR_W = 7;
   localparam int PAT_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [PAT_W-1:0]  pat;
   } cl_word_t;

endpackage

// File: rtl/cluster_finder_if.sv
// Upstream load port and downstream cluster-word port of the cluster finder.
interface cluster_finder_if;
   import cluster_finder_pkg::*;

   logic              load_i;
   logic [STRIPS-1:0] hits_i;
   logic              busy_o;
   logic              cl_valid_o;
   logic              cl_ready_i;
   logic [ADDR_W-1:0] cl_addr_o;
   logic [PAT_W-1:0]  cl_pat_o;
   logic              cl_last_o;
   logic              done_o;
   logic              overflow_o;

   // Environment side: drives the load and the downstream ready
   modport master (
      output load_i, hits_i, cl_ready_i,
      input  busy_o, cl_valid_o, cl_addr_o, cl_pat_o, cl_last_o, done_o, overflow_o
   );

   // Finder side
   modport slave (
      input  load_i, hits_i, cl_ready_i,
      output busy_o, cl_valid_o, cl_addr_o, cl_pat_o, cl_last_o, done_o, overflow_o
   );

endinterface

// File: rtl/cluster_prio_enc.sv
// Combinational highest-set-bit encoder over the strip map, built as a
// binary tree: each level merges pairs of nodes, preferring the upper one.
module cluster_prio_enc
   import cluster_finder_pkg::*;
(
   input  logic [STRIPS-1:0] hits,
   output logic [ADDR_W-1:0] idx,
   output logic              any
);

   genvar gi, gj;
   generate
      for (gi = 0; gi <= ADDR_W; gi++) begin : lvl_g
         localparam int N = STRIPS >> gi;
         logic [N-1:0]             v;
         logic [N-1:0][ADDR_W-1:0] ix;
         for (gj = 0; gj < N; gj++) begin : node_g
            if (gi == 0) begin : leaf_g
               assign v[gj]  = hits[gj];
               assign ix[gj] = ADDR_W'(gj);
            end else begin : join_g
               assign v[gj]  = lvl_g[gi-1].v[2*gj+1] | lvl_g[gi-1].v[2*gj];
               assign ix[gj] = lvl_g[gi-1].v[2*gj+1] ? lvl_g[gi-1].ix[2*gj+1]
                                                     : lvl_g[gi-1].ix[2*gj];
            end
         end
      end
   endgenerate

   assign any = lvl_g[ADDR_W].v[0];
   assign idx = lvl_g[ADDR_W].ix[0];

endmodule

// File: rtl/cluster_finder.sv
// Sequential cluster finder: captures a strip hit map and emits one
// cluster word per cycle from the highest strip downward, consuming a
// 4-strip window per word, until the map is empty or MAX_CL is reached.
module cluster_finder
   import cluster_finder_pkg::*;
#(
   parameter int MAX_CL = 32
) (
   input  logic             clk,
   input  logic             rstb,
   cluster_finder_if.slave  bus
);

   localparam int CNT_W = $clog2(MAX_CL + 1);

   state_t            state_reg, state_next;
   logic [STRIPS-1:0] map_reg, map_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   cl_word_t          word_reg, word_next;
   logic              valid_reg, valid_next;
   logic              last_reg, last_next;
   logic              done_reg, done_next;
   logic              overflow_reg, overflow_next;

   logic [ADDR_W-1:0]   seed;
   logic                any;
   logic [STRIPS+2:0]   ext_map;
   logic [PAT_W-1:0]    pat_win;
   logic [STRIPS-1:0]   clear_mask;
   logic [STRIPS-1:0]   map_left;
   logic [CNT_W-1:0]    count_inc;
   logic                take;

   cluster_prio_enc u_prio (
      .hits (map_reg),
      .idx  (seed),
      .any  (any)
   );

   // Three zero strips appended below strip 0 give the padding for the window
   assign ext_map   = {map_reg, 3'b000};
   assign pat_win   = ext_map[seed +: 3];
   assign map_left  = map_reg & ~clear_mask;
   assign count_inc = count_reg + CNT_W'(1);
   assign take      = !valid_reg || bus.cl_ready_i;

   // Clear window covers strips seed down to seed-3, saturating at strip 0
   genvar gi;
   generate
      for (gi = 0; gi < STRIPS; gi++) begin : mask_g
         assign clear_mask[gi] = (ADDR_W'(gi) <= seed) &&
                                 ({1'b0, ADDR_W'(gi)} + 8'd3 >= {1'b0, seed});
      end
   endgenerate

   // State and datapath registers
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_reg    <= IDLE;
         map_reg      <= '0;
         count_reg    <= '0;
         word_reg     <= '0;
         valid_reg    <= 1'b0;
         last_reg     <= 1'b0;
         done_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         map_reg      <= map_next;
         count_reg    <= count_next;
         word_reg     <= word_next;
         valid_reg    <= valid_next;
         last_reg     <= last_next;
         done_reg     <= done_next;
         overflow_reg <= overflow_next;
      end
   end

   // Next-state and extraction logic; everything holds unless a step fires
   always_comb begin
      state_next    = state_reg;
      map_next      = map_reg;
      count_next    = count_reg;
      word_next     = word_reg;
      valid_next    = valid_reg;
      last_next     = last_reg;
      done_next     = 1'b0;
      overflow_next = overflow_reg;
      unique case (state_reg)
         IDLE: begin
            // The done cycle itself still refuses a load
            if (bus.load_i && !done_reg) begin
               map_next      = bus.hits_i;
               count_next    = '0;
               overflow_next = 1'b0;
               state_next    = SCAN;
            end
         end
         SCAN: begin
            if (take) begin
               if (!any) begin
                  valid_next = 1'b0;
                  last_next  = 1'b0;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  word_next.addr = seed;
                  word_next.pat  = pat_win;
                  valid_next     = 1'b1;
                  map_next       = map_left;
                  count_next     = count_inc;
                  last_next      = (map_left == '0) || (count_inc == CNT_W'(MAX_CL));
                  if ((count_inc == CNT_W'(MAX_CL)) && (map_left != '0))
                     overflow_next = 1'b1;
                  if (last_next)
                     state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (bus.cl_ready_i) begin
               valid_next = 1'b0;
               last_next  = 1'b0;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.busy_o     = (state_reg != IDLE);
   assign bus.cl_valid_o = valid_reg;
   assign bus.cl_addr_o  = word_reg.addr;
   assign bus.cl_pat_o   = word_reg.pat;
   assign bus.cl_last_o  = last_reg;
   assign bus.done_o     = done_reg;
   assign bus.overflow_o = overflow_reg;

endmodule

// File: tb/tb_cluster_finder.sv
// Directed bench for cluster_finder: one instance with the default cap and
// one with MAX_CL=8, driven on negative edges and checked between edges.
module tb_cluster_finder;

   logic clk;
   logic rstb;
   int   total = 0;
   int   bad   = 0;
   logic [127:0] h;

   cluster_finder_if bus_a ();
   cluster_finder_if bus_b ();

   cluster_finder #(.MAX_CL(32)) dut_a (.clk(clk), .rstb(rstb), .bus(bus_a));
   cluster_finder #(.MAX_CL(8))  dut_b (.clk(clk), .rstb(rstb), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic load_a(input logic [127:0] hv);
      bus_a.hits_i = hv;
      bus_a.load_i = 1'b1;
      step();
      bus_a.load_i = 1'b0;
      bus_a.hits_i = '0;
   endtask

   task automatic load_b(input logic [127:0] hv);
      bus_b.hits_i = hv;
      bus_b.load_i = 1'b1;
      step();
      bus_b.load_i = 1'b0;
      bus_b.hits_i = '0;
   endtask

   initial begin
      rstb = 1'b0;
      bus_a.load_i = 1'b0; bus_a.hits_i = '0; bus_a.cl_ready_i = 1'b1;
      bus_b.load_i = 1'b0; bus_b.hits_i = '0; bus_b.cl_ready_i = 1'b1;
      step(); step();

      // Reset state
      chk("rst_busy", bus_a.busy_o, 0);
      chk("rst_valid", bus_a.cl_valid_o, 0);
      chk("rst_last", bus_a.cl_last_o, 0);
      chk("rst_done", bus_a.done_o, 0);
      chk("rst_ovf", bus_a.overflow_o, 0);
      chk("rst_addr", bus_a.cl_addr_o, 0);
      chk("rst_pat", bus_a.cl_pat_o, 0);
      rstb = 1'b1;
      step();

      // Single hit at strip 127
      h = '0; h[127] = 1'b1;
      load_a(h);
      chk("s127_busy", bus_a.busy_o, 1);
      chk("s127_novalid", bus_a.cl_valid_o, 0);
      step();
      chk("s127_valid", bus_a.cl_valid_o, 1);
      chk("s127_addr", bus_a.cl_addr_o, 127);
      chk("s127_pat", bus_a.cl_pat_o, 0);
      chk("s127_last", bus_a.cl_last_o, 1);
      step();
      chk("s127_done", bus_a.done_o, 1);
      chk("s127_vclr", bus_a.cl_valid_o, 0);
      chk("s127_ovf", bus_a.overflow_o, 0);
      chk("s127_idle", bus_a.busy_o, 0);
      step();
      chk("s127_done_pulse", bus_a.done_o, 0);

      // Hits {5,4,2}
      h = '0; h[5] = 1'b1; h[4] = 1'b1; h[2] = 1'b1;
      load_a(h);
      step();
      chk("h542_addr", bus_a.cl_addr_o, 5);
      chk("h542_pat", bus_a.cl_pat_o, 3'b101);
      chk("h542_last", bus_a.cl_last_o, 1);
      step();
      chk("h542_done", bus_a.done_o, 1);
      step();

      // Hits {2,0}: padding below strip 0
      h = '0; h[2] = 1'b1; h[0] = 1'b1;
      load_a(h);
      step();
      chk("h20_addr", bus_a.cl_addr_o, 2);
      chk("h20_pat", bus_a.cl_pat_o, 3'b010);
      chk("h20_last", bus_a.cl_last_o, 1);
      step();
      chk("h20_done", bus_a.done_o, 1);
      step();

      // All hits, cap 32
      load_a('1);
      for (int i = 0; i < 32; i++) begin
         step();
         chk($sformatf("full32_valid%0d", i), bus_a.cl_valid_o, 1);
         chk($sformatf("full32_addr%0d", i), bus_a.cl_addr_o, 127 - 4 * i);
         chk($sformatf("full32_pat%0d", i), bus_a.cl_pat_o, 3'b111);
         chk($sformatf("full32_last%0d", i), bus_a.cl_last_o, (i == 31) ? 1 : 0);
      end
      step();
      chk("full32_done", bus_a.done_o, 1);
      chk("full32_valid_end", bus_a.cl_valid_o, 0);
      chk("full32_ovf", bus_a.overflow_o, 0);
      step();

      // All hits, cap 8: overflow
      load_b('1);
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("full8_addr%0d", i), bus_b.cl_addr_o, 127 - 4 * i);
         chk($sformatf("full8_pat%0d", i), bus_b.cl_pat_o, 3'b111);
         chk($sformatf("full8_last%0d", i), bus_b.cl_last_o, (i == 7) ? 1 : 0);
      end
      step();
      chk("full8_done", bus_b.done_o, 1);
      chk("full8_ovf", bus_b.overflow_o, 1);
      step();
      chk("full8_ovf_sticky", bus_b.overflow_o, 1);
      h = '0; h[0] = 1'b1;
      load_b(h);
      chk("full8_ovf_clr", bus_b.overflow_o, 0);
      step();
      chk("b0_addr", bus_b.cl_addr_o, 0);
      chk("b0_pat", bus_b.cl_pat_o, 0);
      chk("b0_last", bus_b.cl_last_o, 1);
      step();
      chk("b0_done", bus_b.done_o, 1);
      step();

      // Hits {100,50} with backpressure on the first word
      bus_a.cl_ready_i = 1'b0;
      h = '0; h[100] = 1'b1; h[50] = 1'b1;
      load_a(h);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("bp_valid%0d", i), bus_a.cl_valid_o, 1);
         chk($sformatf("bp_addr%0d", i), bus_a.cl_addr_o, 100);
         chk($sformatf("bp_last%0d", i), bus_a.cl_last_o, 0);
      end
      bus_a.cl_ready_i = 1'b1;
      step();
      chk("bp_addr50", bus_a.cl_addr_o, 50);
      chk("bp_pat50", bus_a.cl_pat_o, 0);
      chk("bp_last50", bus_a.cl_last_o, 1);
      step();
      chk("bp_done", bus_a.done_o, 1);
      chk("bp_valid_end", bus_a.cl_valid_o, 0);
      step();

      // Empty map
      load_a('0);
      chk("empty_busy", bus_a.busy_o, 1);
      chk("empty_novalid", bus_a.cl_valid_o, 0);
      step();
      chk("empty_done", bus_a.done_o, 1);
      chk("empty_valid", bus_a.cl_valid_o, 0);
      chk("empty_idle", bus_a.busy_o, 0);
      step();

      // Load during busy is ignored; load in the done cycle is ignored
      bus_a.cl_ready_i = 1'b0;
      h = '0; h[10] = 1'b1;
      load_a(h);
      step();
      chk("lb_addr", bus_a.cl_addr_o, 10);
      h = '0; h[120] = 1'b1;
      load_a(h);
      chk("lb_busy", bus_a.busy_o, 1);
      chk("lb_hold_addr", bus_a.cl_addr_o, 10);
      chk("lb_hold_last", bus_a.cl_last_o, 1);
      bus_a.cl_ready_i = 1'b1;
      step();
      chk("lb_done", bus_a.done_o, 1);
      h = '0; h[60] = 1'b1;
      load_a(h);
      chk("lb_done_load_busy", bus_a.busy_o, 0);
      chk("lb_done_load_valid", bus_a.cl_valid_o, 0);
      step();
      chk("lb_no_word", bus_a.cl_valid_o, 0);
      chk("lb_no_done", bus_a.done_o, 0);

      // Asynchronous reset mid-scan
      load_a('1);
      step();
      step();
      chk("mid_valid_pre", bus_a.cl_valid_o, 1);
      #2 rstb = 1'b0;
      #1;
      chk("mid_rst_valid", bus_a.cl_valid_o, 0);
      chk("mid_rst_busy", bus_a.busy_o, 0);
      chk("mid_rst_addr", bus_a.cl_addr_o, 0);
      chk("mid_rst_pat", bus_a.cl_pat_o, 0);
      chk("mid_rst_last", bus_a.cl_last_o, 0);
      step();
      rstb = 1'b1;
      step();
      chk("mid_rst_nodone", bus_a.done_o, 0);
      h = '0; h[3] = 1'b1;
      load_a(h);
      step();
      chk("post_rst_addr", bus_a.cl_addr_o, 3);
      chk("post_rst_pat", bus_a.cl_pat_o, 0);
      chk("post_rst_last", bus_a.cl_last_o, 1);
      chk("post_rst_ovf", bus_a.overflow_o, 0);
      step();
      chk("post_rst_done", bus_a.done_o, 1);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
